esn_readout: RTL



---
 rtl/esn_readout.sv | 135 +++++++++++++
 1 files changed

// File: rtl/esn_readout.sv
// Echo state network readout: y = bias + sum(w[i]*x[i]), one shared MAC.
// Optional ESN_READOUT_SATCNT_EN adds a saturating clip counter port sat_cnt.
module esn_readout #(
  parameter int WIDTH  = 16,
  parameter int NSTATE = 8,
  parameter int FRAC   = 12,
  parameter int AW     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSTATE*WIDTH-1:0]  xstate,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_drop,
  output logic [WIDTH-1:0]         y,
  output logic                     y_valid
`ifdef ESN_READOUT_SATCNT_EN
  ,
  output logic [15:0]              sat_cnt
`endif
);

  localparam int ACCW = 2*WIDTH + $clog2(NSTATE+1) + 1;
  localparam int IW   = (NSTATE > 1) ? $clog2(NSTATE) : 1;

  localparam logic signed [ACCW-1:0] HALF = ACCW'(1) << (FRAC-1);
  localparam logic signed [ACCW-1:0] YMAX =
    {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] YMIN = ~YMAX;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND
  } state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] w  [NSTATE];
  logic signed [WIDTH-1:0] xs [NSTATE];
  logic signed [WIDTH-1:0] bias;
  logic signed [ACCW-1:0]  acc;
  logic [IW-1:0]           idx;

  logic                    hs;
  logic                    wr_hit;
  logic                    wr_ok;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACCW-1:0]  sum;
  logic signed [ACCW-1:0]  rnd;
  logic [WIDTH-1:0]        ysat;
  logic                    clip;

  assign hs     = x_valid && x_ready;
  assign wr_hit = wr_en && (wr_addr <= AW'(NSTATE));
  assign wr_ok  = wr_hit && (state == IDLE) && !hs;
  assign prod   = xs[idx] * w[idx];

  // Round half up, then clip to the signed output range.
  always_comb begin
    sum  = acc + HALF;
    rnd  = sum >>> FRAC;
    clip = 1'b0;
    ysat = rnd[WIDTH-1:0];
    if (rnd > YMAX) begin
      clip = 1'b1;
      ysat = YMAX[WIDTH-1:0];
    end else if (rnd < YMIN) begin
      clip = 1'b1;
      ysat = YMIN[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      x_ready <= 1'b1;
      y       <= '0;
      y_valid <= 1'b0;
      wr_drop <= 1'b0;
      acc     <= '0;
      idx     <= '0;
      bias    <= '0;
      for (int i = 0; i < NSTATE; i++) begin
        w[i]  <= '0;
        xs[i] <= '0;
      end
`ifdef ESN_READOUT_SATCNT_EN
      sat_cnt <= '0;
`endif
    end else begin
      y_valid <= 1'b0;
      if (wr_hit) begin
        if (!wr_ok)
          wr_drop <= 1'b1;
        else if (wr_addr == AW'(NSTATE))
          bias <= wr_data;
        else
          w[wr_addr[IW-1:0]] <= wr_data;
      end
      unique case (state)
        IDLE: begin
          if (hs) begin
            for (int i = 0; i < NSTATE; i++)
              xs[i] <= xstate[i*WIDTH +: WIDTH];
            acc <= {{(ACCW-WIDTH){bias[WIDTH-1]}}, bias} << FRAC;
            idx     <= '0;
            x_ready <= 1'b0;
            state   <= MAC;
          end
        end
        MAC: begin
          acc <= acc + {{(ACCW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
          idx <= idx + 1'b1;
          if (idx == IW'(NSTATE-1))
            state <= ROUND;
        end
        ROUND: begin
          y       <= ysat;
          y_valid <= 1'b1;
          x_ready <= 1'b1;
          state   <= IDLE;
`ifdef ESN_READOUT_SATCNT_EN
          if (clip && sat_cnt != 16'hFFFF)
            sat_cnt <= sat_cnt + 16'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
